// File: rtl/uart_rx_word_packer_pkg.sv
// rtl/uart_rx_word_packer_pkg.sv - shared UART word-packer constants and assembler state codes
package uart_rx_word_packer_pkg;

  // Bytes assembled into one little-endian word
  localparam int BYTES_PER_WORD = 4;

  // Default byte-silence window before a partial word is flushed
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

  // Word width and stored FIFO entry width ({partial, data})
  localparam int WORD_W  = 8 * BYTES_PER_WORD;
  localparam int ENTRY_W = WORD_W + 1;

  // Assembler states: IDLE holds no bytes, COLLECT holds 1..3 bytes
  typedef enum logic [0:0] {
    PACK_IDLE    = 1'b0,
    PACK_COLLECT = 1'b1
  } pack_state_t;

endpackage

// File: rtl/uart_word_fifo.sv
// rtl/uart_word_fifo.sv - first-word-fall-through word FIFO with count and full/empty flags
module uart_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;

  // A pop on an empty FIFO is ignored; a push on a full FIFO only lands if a pop frees a slot
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  // Head is forced to zero while empty so outputs read as zero after reset or clear
  assign head = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written on an accepted push, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (w_push_ok && !clear) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy count; clear flushes everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_word_packer.sv
// rtl/uart_rx_word_packer.sv - packs UART bytes into 32-bit words, buffers them; optional UART_RX_TIMEOUT_EN flush
module uart_rx_word_packer
  import uart_rx_word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                          clk,
  input  logic                          SYS_reset_n,
  input  logic                          clear,
  input  logic [7:0]                    rx_byte,
  input  logic                          rx_byte_valid,
  output logic [31:0]                   word_data,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          word_partial,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  pack_state_t        r_state;
  pack_state_t        w_state_nxt;
  logic [1:0]         r_idx;
  logic [1:0]         w_idx_nxt;
  logic [WORD_W-1:0]  r_shift;
  logic [WORD_W-1:0]  w_shift_nxt;
  logic [WORD_W-1:0]  w_word;
  logic               w_push;
  logic               w_push_partial;
  logic [WORD_W-1:0]  w_push_data;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [ENTRY_W-1:0] w_head;
  logic               r_overflow;

`ifdef UART_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;
  logic          w_timeout;

  assign w_timeout = (r_state == PACK_COLLECT) && (r_timer == TW'(TIMEOUT_CYCLES - 1));
`endif

  assign w_pop = ~w_empty & word_ready;

  // Assembler next-state: store incoming byte at its lane, push on the 4th byte or on timeout
  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_shift_nxt    = r_shift;
    w_push         = 1'b0;
    w_push_partial = 1'b0;
    w_push_data    = r_shift;
    w_word         = r_shift;
    w_word[{r_idx, 3'b000} +: 8] = rx_byte;
    if (clear) begin
      w_state_nxt = PACK_IDLE;
      w_idx_nxt   = 2'd0;
      w_shift_nxt = '0;
    end else if (rx_byte_valid) begin
      if (r_idx == 2'd3) begin
        w_push      = 1'b1;
        w_push_data = w_word;
        w_state_nxt = PACK_IDLE;
        w_idx_nxt   = 2'd0;
        w_shift_nxt = '0;
      end else begin
        w_shift_nxt = w_word;
        w_idx_nxt   = r_idx + 2'd1;
        w_state_nxt = PACK_COLLECT;
      end
    end
`ifdef UART_RX_TIMEOUT_EN
    else if (w_timeout) begin
      // Missing upper bytes are already zero in the shift register
      w_push         = 1'b1;
      w_push_partial = 1'b1;
      w_push_data    = r_shift;
      w_state_nxt    = PACK_IDLE;
      w_idx_nxt      = 2'd0;
      w_shift_nxt    = '0;
    end
`endif
  end

  // Assembler state register
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_state <= PACK_IDLE;
      r_idx   <= 2'd0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  // Silence counter: runs only while collecting, restarts on every byte
  always_comb begin
    w_timer_nxt = '0;
    if (!clear && !rx_byte_valid && (w_state_nxt == PACK_COLLECT)) begin
      w_timer_nxt = r_timer + 1'b1;
    end
  end

  // Silence counter register
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_nxt;
    end
  end
`endif

  // Sticky overflow: set when a completed word finds the FIFO full with no pop to make room
  always_ff @(posedge clk or negedge SYS_reset_n) begin
    if (!SYS_reset_n) begin
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  uart_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (SYS_reset_n),
    .clear     (clear),
    .push      (w_push),
    .push_data ({w_push_partial, w_push_data}),
    .pop       (word_ready),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (fifo_count)
  );

  assign word_data    = w_head[WORD_W-1:0];
  assign word_partial = w_head[WORD_W];
  assign word_valid   = ~w_empty;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_rx_word_packer.sv
// tb/tb_uart_rx_word_packer.sv - directed self-checking bench for uart_rx_word_packer
module tb_uart_rx_word_packer;

  logic        clk = 1'b0;
  logic        SYS_reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_byte_valid = 1'b0;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready = 1'b0;
  logic        word_partial;
  logic [2:0]  fifo_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_word_packer #(
    .FIFO_DEPTH     (4),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk           (clk),
    .SYS_reset_n   (SYS_reset_n),
    .clear         (clear),
    .rx_byte       (rx_byte),
    .rx_byte_valid (rx_byte_valid),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .word_partial  (word_partial),
    .fifo_count    (fifo_count),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte       = b;
    rx_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
  endtask

  task automatic drain_one(input logic [31:0] exp, input string name);
    @(negedge clk);
    n_vec++;
    if (word_valid !== 1'b1 || word_data !== exp) begin
      n_err++;
      $display("FAIL %s: valid=%b data=%h, expected valid=1 data=%h", name, word_valid, word_data, exp);
    end
    word_ready = 1'b1;
    @(posedge clk);
    #1;
    word_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({word_data, word_valid, word_partial, fifo_count, overflow} !== 38'd0) begin
      n_err++;
      $display("FAIL reset_outputs: data=%h valid=%b partial=%b count=%0d ovf=%b, expected all zero",
               word_data, word_valid, word_partial, fifo_count, overflow);
    end
    @(negedge clk);
    SYS_reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_word;
    word_ready = 1'b1;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    n_vec++;
    if (word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_before_4th: valid=%b, expected 0", word_valid);
    end
    send_byte(8'h44);
    n_vec++;
    if (word_valid !== 1'b1 || word_data !== 32'h44332211 || fifo_count !== 3'd1 || word_partial !== 1'b0) begin
      n_err++;
      $display("FAIL single_word: valid=%b data=%h count=%0d partial=%b, expected 1 44332211 1 0",
               word_valid, word_data, fifo_count, word_partial);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (word_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL single_popped: valid=%b count=%0d, expected 0 0", word_valid, fifo_count);
    end
    word_ready = 1'b0;
  endtask

  task automatic test_overflow;
    logic [31:0] words [5];
    words[0] = 32'h13121110;
    words[1] = 32'h23222120;
    words[2] = 32'h33323130;
    words[3] = 32'h43424140;
    words[4] = 32'h53525150;
    for (int i = 0; i < 4; i++) send_word(words[i]);
    n_vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_fill: count=%0d ovf=%b, expected 4 0", fifo_count, overflow);
    end
    send_word(words[4]);
    n_vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drop: count=%0d ovf=%b, expected 4 1", fifo_count, overflow);
    end
    for (int i = 0; i < 4; i++) drain_one(words[i], "ovf_drain");
    n_vec++;
    if (word_valid !== 1'b0 || fifo_count !== 3'd0 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_after_drain: valid=%b count=%0d ovf=%b, expected 0 0 1", word_valid, fifo_count, overflow);
    end
  endtask

  task automatic test_clear;
    send_word(32'h0A0B0C0D);
    send_word(32'h1A1B1C1D);
    send_word(32'h2A2B2C2D);
    send_byte(8'h5F);
    n_vec++;
    if (fifo_count !== 3'd3 || overflow !== 1'b1) begin
      n_err++;
      $display("FAIL clear_setup: count=%0d ovf=%b, expected 3 1", fifo_count, overflow);
    end
    @(negedge clk);
    clear         = 1'b1;
    rx_byte       = 8'hEE;
    rx_byte_valid = 1'b1;
    @(posedge clk);
    #1;
    clear         = 1'b0;
    rx_byte_valid = 1'b0;
    n_vec++;
    if (fifo_count !== 3'd0 || overflow !== 1'b0 || word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL clear: count=%0d ovf=%b valid=%b, expected 0 0 0", fifo_count, overflow, word_valid);
    end
    send_word(32'h64636261);
    n_vec++;
    if (fifo_count !== 3'd1 || word_data !== 32'h64636261) begin
      n_err++;
      $display("FAIL clear_fresh_word: count=%0d data=%h, expected 1 64636261", fifo_count, word_data);
    end
    drain_one(32'h64636261, "clear_drain");
  endtask

  task automatic test_full_push_pop;
    send_word(32'h74737271);
    send_word(32'h78777675);
    send_word(32'h7C7B7A79);
    send_word(32'h807F7E7D);
    send_byte(8'h81);
    send_byte(8'h82);
    send_byte(8'h83);
    word_ready = 1'b1;
    send_byte(8'h84);
    word_ready = 1'b0;
    n_vec++;
    if (fifo_count !== 3'd4 || overflow !== 1'b0 || word_data !== 32'h78777675) begin
      n_err++;
      $display("FAIL full_push_pop: count=%0d ovf=%b data=%h, expected 4 0 78777675", fifo_count, overflow, word_data);
    end
    drain_one(32'h78777675, "full_drain_b");
    drain_one(32'h7C7B7A79, "full_drain_c");
    drain_one(32'h807F7E7D, "full_drain_d");
    drain_one(32'h84838281, "full_drain_e");
  endtask

  task automatic test_back_to_back;
    send_word(32'h94939291);
    send_byte(8'hA1);
    send_byte(8'hA2);
    send_byte(8'hA3);
    word_ready = 1'b1;
    send_byte(8'hA4);
    word_ready = 1'b0;
    n_vec++;
    if (word_valid !== 1'b1 || fifo_count !== 3'd1 || word_data !== 32'hA4A3A2A1) begin
      n_err++;
      $display("FAIL one_entry_push_pop: valid=%b count=%0d data=%h, expected 1 1 a4a3a2a1",
               word_valid, fifo_count, word_data);
    end
    drain_one(32'hA4A3A2A1, "b2b_drain");
  endtask

  task automatic test_reset_mid_word;
    send_word(32'hC4C3C2C1);
    send_byte(8'hAA);
    send_byte(8'hBB);
    @(negedge clk);
    #2;
    SYS_reset_n = 1'b0;
    #1;
    n_vec++;
    if (word_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL async_reset: valid=%b count=%0d, expected 0 0", word_valid, fifo_count);
    end
    @(negedge clk);
    SYS_reset_n = 1'b1;
    send_word(32'h04030201);
    n_vec++;
    if (word_valid !== 1'b1 || fifo_count !== 3'd1 || word_data !== 32'h04030201) begin
      n_err++;
      $display("FAIL reset_no_leftover: valid=%b count=%0d data=%h, expected 1 1 04030201",
               word_valid, fifo_count, word_data);
    end
    drain_one(32'h04030201, "reset_drain");
  endtask

  task automatic test_timeout;
    send_byte(8'h5A);
`ifdef UART_RX_TIMEOUT_EN
    repeat (99) @(posedge clk);
    #1;
    n_vec++;
    if (word_valid !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_early: valid=%b, expected 0", word_valid);
    end
    @(posedge clk);
    #1;
    n_vec++;
    if (word_valid !== 1'b1 || word_data !== 32'h0000005A || word_partial !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_flush: valid=%b data=%h partial=%b, expected 1 0000005a 1",
               word_valid, word_data, word_partial);
    end
    drain_one(32'h0000005A, "timeout_drain");
`else
    repeat (10000) @(posedge clk);
    #1;
    n_vec++;
    if (word_valid !== 1'b0 || fifo_count !== 3'd0 || word_partial !== 1'b0) begin
      n_err++;
      $display("FAIL no_timeout: valid=%b count=%0d partial=%b, expected 0 0 0", word_valid, fifo_count, word_partial);
    end
    send_byte(8'hB1);
    send_byte(8'hB2);
    send_byte(8'hB3);
    n_vec++;
    if (word_valid !== 1'b1 || word_data !== 32'hB3B2B15A || word_partial !== 1'b0) begin
      n_err++;
      $display("FAIL no_timeout_resume: valid=%b data=%h partial=%b, expected 1 b3b2b15a 0",
               word_valid, word_data, word_partial);
    end
    drain_one(32'hB3B2B15A, "no_timeout_drain");
`endif
  endtask

  initial begin
    test_reset;
    test_single_word;
    test_overflow;
    test_clear;
    test_full_push_pop;
    test_back_to_back;
    test_reset_mid_word;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
